// File: rtl/dut_capture_pkg.sv
// Shared types and the MISR step used by the result-capture block.
// The MISR step is width-generic so any OUT_W up to MisrMaxW can share it.
package dut_capture_pkg;

  localparam int unsigned OutW     = 10;
  localparam int unsigned MisrMaxW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StDrain,
    StDone
  } state_e;

  // Shift left, fold the outgoing MSB back through the taps, then mix in the data word.
  function automatic logic [MisrMaxW-1:0] misr_step(input logic [MisrMaxW-1:0] sig,
                                                    input logic [MisrMaxW-1:0] data,
                                                    input logic [MisrMaxW-1:0] poly,
                                                    input int unsigned         width);
    logic [MisrMaxW-1:0] mask;
    logic [MisrMaxW-1:0] msb;
    logic [MisrMaxW-1:0] fb;
    mask = {MisrMaxW{1'b1}} >> (MisrMaxW - width);
    msb  = MisrMaxW'(1) << (width - 1);
    fb   = ((sig & msb) != '0) ? poly : '0;
    return ((sig << 1) ^ fb ^ data) & mask;
  endfunction

endpackage

// File: rtl/dut_result_capture_if.sv
// Result-word input stream and writeback output stream of the capture unit.
interface dut_result_capture_if #(
  parameter int unsigned OUT_W = dut_capture_pkg::OutW
) ();

  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  // master: the stimulus side / writeback sink; slave: the capture unit.
  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/capture_fifo.sv
// Synchronous first-word-fall-through FIFO with extra-MSB pointers for full/empty.
// When empty, head keeps showing the most recently popped word.
module capture_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] last_q;
  logic             do_push, do_pop;

  assign full    = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? last_q : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      last_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + PW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PW'(1);
        last_q <= mem_q[rptr_q[AW-1:0]];
      end
    end
  end

  // Storage needs no reset: nothing is read from it while the pointers say empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/dut_result_capture.sv
// Captures one DUT result word per vector into a FIFO, folds each into a MISR signature
// and counts vectors, so netlists can be compared by signature as well as by dump.
module dut_result_capture
  import dut_capture_pkg::*;
#(
  parameter int unsigned      OUT_W = OutW,
  parameter int unsigned      DEPTH = 8,
  parameter int unsigned      CNT_W = 16,
  parameter logic [OUT_W-1:0] POLY  = OUT_W'(10'h009),
  parameter logic [OUT_W-1:0] SEED  = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  dut_result_capture_if.slave bus,
  output logic [OUT_W-1:0]    sig,
  output logic [CNT_W-1:0]    vec_count,
  output logic                done
);

  state_e state_q, state_d;

  logic [OUT_W-1:0]    sig_q, sig_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MisrMaxW-1:0] misr_full;
  logic                unused_misr;
  logic                fifo_full, fifo_empty;
  logic [OUT_W-1:0]    fifo_head;
  logic                in_ready;
  logic                accept, pop, run_start;

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready  = (state_q == StCapture) && !fifo_full;
  assign accept    = bus.in_valid && in_ready;
  assign pop       = !fifo_empty && bus.out_ready;
  assign run_start = start && ((state_q == StIdle) || (state_q == StDone));

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_head;
  assign sig           = sig_q;
  assign vec_count     = cnt_q;
  assign done          = (state_q == StDone);

  capture_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .wdata (bus.in_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (start) state_d = StCapture;
      StCapture: if (accept && bus.in_last) state_d = StDrain;
      StDrain:   if (fifo_empty) state_d = StDone;
      StDone:    if (start) state_d = StCapture;
      default:   state_d = StIdle;
    endcase
  end

  assign misr_full   = misr_step(MisrMaxW'(sig_q), MisrMaxW'(bus.in_data), MisrMaxW'(POLY),
                                 OUT_W);
  assign unused_misr = ^misr_full[MisrMaxW-1:OUT_W];

  always_comb begin
    sig_d = sig_q;
    cnt_d = cnt_q;
    if (run_start) begin
      sig_d = SEED;
      cnt_d = '0;
    end else if (accept) begin
      sig_d = misr_full[OUT_W-1:0];
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sig_q   <= SEED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dut_result_capture.sv
// Randomised scoreboard bench for dut_result_capture against a run-level reference model.
module tb_dut_result_capture;

  localparam int unsigned W = 10;
  localparam int unsigned D = 8;

  typedef enum {PIdle, PCap, PDrain, PDone} phase_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;

  always #5 clk = ~clk;

  dut_result_capture_if #(.OUT_W(W)) bus ();
  dut_result_capture_if #(.OUT_W(W)) bus2 ();

  logic [W-1:0] sig, sig2;
  logic [15:0]  vc;
  logic [1:0]   vc2;
  logic         done, done2;

  dut_result_capture #(
    .OUT_W (W), .DEPTH (D), .CNT_W (16), .POLY (10'h009), .SEED (10'h000)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .bus (bus),
    .sig (sig), .vec_count (vc), .done (done)
  );

  dut_result_capture #(
    .OUT_W (W), .DEPTH (D), .CNT_W (2), .POLY (10'h009), .SEED (10'h000)
  ) dut2 (
    .clk (clk), .rst (rst), .start (start2), .bus (bus2),
    .sig (sig2), .vec_count (vc2), .done (done2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Signature as polynomial arithmetic: s*x mod (x^10+x^3+1), plus the data word.
  function automatic logic [W-1:0] ref_misr(input logic [W-1:0] s, input logic [W-1:0] d);
    logic [W:0] t;
    t = {s, 1'b0};
    if (t[W]) t = t ^ 11'h409;
    return t[W-1:0] ^ d;
  endfunction

  // Reference model: run phase, occupancy, signature, count, and expected output order.
  phase_t       m_phase = PIdle;
  int           m_occ = 0;
  int           m_cnt = 0;
  logic [W-1:0] m_sig = '0;
  logic [W-1:0] sb[$];
  logic         a_rdy, a_acc, a_pop;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_phase = PIdle;
        m_occ   = 0;
        m_cnt   = 0;
        m_sig   = '0;
        sb.delete();
        continue;
      end
      a_rdy = (m_phase == PCap) && (m_occ < D);
      chk("in_ready", 32'(bus.in_ready), 32'(a_rdy));
      chk("out_valid", 32'(bus.out_valid), 32'(m_occ > 0));
      chk("sig", 32'(sig), 32'(m_sig));
      chk("vec_count", 32'(vc), 32'(m_cnt));
      chk("done", 32'(done), 32'(m_phase == PDone));
      a_acc = bus.in_valid && a_rdy;
      a_pop = (m_occ > 0) && bus.out_ready;
      if (a_acc) begin
        sb.push_back(bus.in_data);
        m_sig = ref_misr(m_sig, bus.in_data);
        if (m_cnt < 65535) m_cnt++;
      end
      case (m_phase)
        PIdle, PDone: if (start) begin
          m_phase = PCap;
          m_sig   = '0;
          m_cnt   = 0;
        end
        PCap:   if (a_acc && bus.in_last) m_phase = PDrain;
        PDrain: if (m_occ == 0) m_phase = PDone;
        default: ;
      endcase
      m_occ = m_occ + (a_acc ? 1 : 0) - (a_pop ? 1 : 0);
    end
  end

  // Output monitor: every word handed to the sink must be the next expected one.
  logic [W-1:0] mon_exp;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("out_unexpected", 32'(bus.out_valid), 32'(0));
        end else begin
          mon_exp = sb.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(mon_exp));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input logic last);
    logic ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      tick(1);
      if (ok) break;
    end
    if (!ok) chk("send_timeout", 32'(ok), 32'(1));
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_done();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (m_phase == PDone) begin
        hit = 1'b1;
        break;
      end
    end
    chk("done_reached", 32'(done), 32'(1));
    if (!hit) chk("done_timeout", 32'(hit), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  logic [W-1:0] w9, s_exp, wd;
  int           seen;

  initial begin
    bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0; bus.out_ready = 0;
    bus2.in_valid = 0; bus2.in_data = '0; bus2.in_last = 0; bus2.out_ready = 0;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Asynchronous reset with three words buffered.
    pulse_start();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(W'($urandom), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_out_data", 32'(bus.out_data), 32'(0));
    chk("rst_sig", 32'(sig), 32'(0));
    chk("rst_vec_count", 32'(vc), 32'(0));
    chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    tick(2);
    rst = 1'b0;
    tick(1);

    // Directed three-word run.
    bus.out_ready = 1'b1;
    pulse_start();
    send(10'h001, 1'b0);
    send(10'h003, 1'b0);
    send(10'h200, 1'b1);
    wait_done();
    chk("directed_sig", 32'(sig), 32'h202);
    chk("directed_vec_count", 32'(vc), 32'd3);

    // Fill to DEPTH, hold a ninth word, then free one slot.
    pulse_start();
    bus.out_ready = 1'b0;
    for (int i = 0; i < D; i++) send(W'($urandom), 1'b0);
    w9 = W'($urandom);
    bus.in_valid = 1'b1;
    bus.in_data  = w9;
    tick(3);
    chk("full_in_ready", 32'(bus.in_ready), 32'(0));
    chk("full_vec_count", 32'(vc), 32'd8);
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    chk("refill_in_ready", 32'(bus.in_ready), 32'(1));
    tick(1);
    bus.in_valid = 1'b0;
    chk("refill_vec_count", 32'(vc), 32'd9);
    bus.out_ready = 1'b1;
    send(W'($urandom), 1'b1);
    wait_done();

    // Concurrent push/pop at occupancy 4; pointers wrap.
    pulse_start();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(W'($urandom), 1'b0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_data = W'($urandom);
      tick(1);
    end
    bus.in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid) seen++;
      tick(1);
    end
    chk("steady_occupancy", 32'(seen), 32'd4);
    send(W'($urandom), 1'b1);
    wait_done();

    // start during capture is ignored; words offered in DONE are refused.
    pulse_start();
    s_exp = '0;
    for (int i = 0; i < 2; i++) begin
      wd = W'($urandom);
      s_exp = ref_misr(s_exp, wd);
      send(wd, 1'b0);
    end
    wd = W'($urandom);
    s_exp = ref_misr(s_exp, wd);
    start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = wd;
    tick(1);
    start = 1'b0;
    bus.in_valid = 1'b0;
    chk("ignored_start_vec_count", 32'(vc), 32'd3);
    wd = W'($urandom);
    s_exp = ref_misr(s_exp, wd);
    send(wd, 1'b1);
    wait_done();
    chk("ignored_start_sig", 32'(sig), 32'(s_exp));
    bus.in_valid = 1'b1;
    bus.in_data  = W'($urandom);
    tick(3);
    chk("done_in_ready", 32'(bus.in_ready), 32'(0));
    chk("done_sig", 32'(sig), 32'(s_exp));
    chk("done_vec_count", 32'(vc), 32'd4);
    bus.in_valid = 1'b0;

    // Random traffic with stray start pulses.
    for (int r = 0; r < 4; r++) begin
      pulse_start();
      for (int c = 0; c < 40; c++) begin
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.in_data   = W'($urandom);
        bus.out_ready = 1'($urandom_range(0, 1));
        start         = ($urandom_range(0, 7) == 0);
        tick(1);
      end
      start = 1'b0;
      bus.out_ready = 1'b1;
      send(W'($urandom), 1'b1);
      wait_done();
    end

    // Two-bit counter saturates.
    bus2.out_ready = 1'b1;
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    s_exp = '0;
    for (int i = 0; i < 5; i++) begin
      wd = W'($urandom);
      s_exp = ref_misr(s_exp, wd);
      bus2.in_valid = 1'b1;
      bus2.in_data  = wd;
      bus2.in_last  = (i == 4);
      tick(1);
    end
    bus2.in_valid = 1'b0;
    bus2.in_last  = 1'b0;
    chk("sat_vec_count", 32'(vc2), 32'd3);
    chk("sat_sig", 32'(sig2), 32'(s_exp));
    tick(3);
    chk("sat_done", 32'(done2), 32'(1));

    tick(5);
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
